axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Sits directly upstream of the two L1 return buffers (icache, dcache); single AXI read-master port toward memory.
- Arbitrates icache/dcache refill and uncached read requests, issues one AR burst at a time, and steers R beats to the requesting buffer.
- Each buffer sees a per-beat valid (`*_rready`), `*_rdata` and `*_rlast`.
- Strictly one outstanding read transaction.

Parameters:
- offset_width, 2: log2 of words per cache line; cached burst = 1<<offset_width beats of 32 bits.
- id_width, 4: AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_req  in  1  icache read request, level, held until i_ack
- i_addr  in  32  icache request address
- i_uncached  in  1  1 = single-word read, 0 = line refill
- i_ack  out  1  one-cycle pulse: AR handshake done for icache
- i_rready  out  1  beat valid toward icache return buffer
- i_rdata  out  32  beat data
- i_rlast  out  1  final beat
- d_req, d_addr, d_uncached, d_ack, d_rready, d_rdata, d_rlast: same as i_* for dcache
- arid  out  id_width  0 = icache, 1 = dcache
- araddr  out  32  burst start address
- arlen  out  8  beats-1
- arsize  out  3  fixed 3'b010
- arburst  out  2  fixed 2'b01 (INCR)
- arvalid  out  1
- arready  in  1
- rid  in  id_width
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1
- bus_err  out  1  one-cycle pulse on bad rresp or beat-count mismatch

Behaviour:
- Reset values: all outputs 0; arsize = 3'b010, arburst = 2'b01 constant. Grant-history bit = icache; state = IDLE.
- Reset mid-operation forces IDLE at the next edge and drops arvalid/rready. The abandoned transaction is not completed; the slave is reset alongside.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - No request pending: stay.
  - Otherwise grant one requester, register arid/araddr/arlen, go to ADDR.
  - Result: arvalid = 1 one cycle after req is sampled.
- Grant rule: only one requesting wins. Both requesting: the one not granted last wins (round-robin). After reset, dcache wins the first tie.
- Address/length:
  - Cached: araddr = addr with low offset_width+2 bits cleared; arlen = (1<<offset_width)-1.
  - Uncached: araddr = addr with bits [1:0] cleared; arlen = 0.
- ADDR:
  - arvalid and all AR fields held stable until arready.
  - On arvalid && arready: pulse owner's *_ack that same cycle, clear arvalid, clear beat counter, go to DATA.
- DATA:
  - rready = 1 combinationally while in DATA.
  - Each rvalid beat drives owner's *_rready = 1, *_rdata = rdata, *_rlast = rlast in the same cycle (combinational pass-through, zero latency). Non-owner outputs stay 0.
  - Beat counter increments per beat.
  - On rvalid && rlast: go to IDLE.
- bus_err pulses the same cycle as the offending beat when:
  - rresp != 0 on any beat, or
  - rlast arrives with counter != arlen, or
  - rid != registered arid.
- Data is forwarded regardless of bus_err. Ending the transaction follows rlast only.
- Back-to-back: earliest next arvalid is 2 cycles after the last beat (IDLE sample, then ADDR).
- A request deasserted before ack is a requester violation; the registered AR is still issued and completed.
- Simultaneous new request during DATA: ignored until IDLE.

Decomposition:
- Shared package (axi_pkg) holds:
  - BURST_INCR = 2'b01, SIZE_WORD = 3'b010, RESP_OKAY = 2'b00
  - ID_ICACHE = 0, ID_DCACHE = 1
  - state encodings IDLE/ADDR/DATA
- No sub-module; the 2-way round-robin is a single history flop inline.

Test Plan:
- Cached icache refill: i_req=1, i_addr=0x1C00_0014, arready=1 immediately, 4 beats A,B,C,D with rvalid every cycle, rlast on D.
  - Expect araddr=0x1C00_0010, arlen=3, arid=0, i_ack one pulse.
  - Expect i_rready high 4 cycles carrying A..D, i_rlast only with D; d_* stay 0.
- Simultaneous requests after reset, both cached: dcache granted first (arid=1, d_ack), icache granted second; then back-to-back dcache + icache again → icache wins the tie.
- Uncached dcache read at 0xBFD0_0003 with arready delayed 5 cycles:
  - Expect araddr=0xBFD0_0000, arlen=0, AR fields stable all 5 cycles, d_ack in handshake cycle.
  - One beat with rlast; IDLE next cycle.
- Gapped R channel: rvalid pattern 1,0,0,1,1,0,1(last) → exactly 4 owner beats in matching cycles, no bus_err.
- Error cases:
  - rresp=2'b10 on beat 2 → bus_err one pulse in that cycle.
  - Separately, rlast on beat 3 of a 4-beat burst → bus_err pulse and return to IDLE.
- Reset asserted during DATA after beat 2 → next cycle arvalid=0, rready=0, all *_rready=0.
- New i_req after reset deassert → issued normally with arvalid 1 cycle later.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI read constants and arbiter state encoding
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int ID_ICACHE = 0;
    localparam int ID_DCACHE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - icache/dcache read arbiter, one outstanding AXI read burst
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int offset_width = 2,
    parameter int id_width     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [31:0]         i_addr,
    input  logic                i_uncached,
    output logic                i_ack,
    output logic                i_rready,
    output logic [31:0]         i_rdata,
    output logic                i_rlast,
    input  logic                d_req,
    input  logic [31:0]         d_addr,
    input  logic                d_uncached,
    output logic                d_ack,
    output logic                d_rready,
    output logic [31:0]         d_rdata,
    output logic                d_rlast,
    output logic [id_width-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [id_width-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic                bus_err
);

    localparam logic [31:0] LINE_MASK = ~((32'd1 << (offset_width + 2)) - 32'd1);
    localparam logic [7:0]  LINE_LEN  = 8'((1 << offset_width) - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner_d;   // owner of current burst; doubles as round-robin history
    logic [id_width-1:0]  r_arid;
    logic [31:0]          r_araddr;
    logic [7:0]           r_arlen;
    logic [7:0]           r_cnt;
    logic                 w_any_req;
    logic                 w_grant_d;
    logic [31:0]          w_addr;
    logic                 w_unc;
    logic                 w_ar_hs;
    logic                 w_beat;

    assign w_any_req = i_req | d_req;
    assign w_grant_d = d_req & (~i_req | ~r_owner_d);
    assign w_addr    = w_grant_d ? d_addr : i_addr;
    assign w_unc     = w_grant_d ? d_uncached : i_uncached;
    assign w_ar_hs   = (r_state == ST_ADDR) & arready;
    assign w_beat    = (r_state == ST_DATA) & rvalid;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner_d <= w_grant_d;
                r_arid    <= w_grant_d ? id_width'(ID_DCACHE) : id_width'(ID_ICACHE);
                r_araddr  <= w_unc ? {w_addr[31:2], 2'b00} : (w_addr & LINE_MASK);
                r_arlen   <= w_unc ? 8'd0 : LINE_LEN;
            end
            if (w_ar_hs) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        arvalid  = 1'b0;
        rready   = 1'b0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        i_rready = 1'b0;
        i_rdata  = '0;
        i_rlast  = 1'b0;
        d_rready = 1'b0;
        d_rdata  = '0;
        d_rlast  = 1'b0;
        bus_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next = ST_DATA;
                    i_ack  = ~r_owner_d;
                    d_ack  = r_owner_d;
                end
            end
            ST_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (r_owner_d) begin
                        d_rready = 1'b1;
                        d_rdata  = rdata;
                        d_rlast  = rlast;
                    end else begin
                        i_rready = 1'b1;
                        i_rdata  = rdata;
                        i_rlast  = rlast;
                    end
                    // Data is still forwarded on error; only rlast ends the burst
                    bus_err = (rresp != RESP_OKAY) | (rlast & (r_cnt != r_arlen)) | (rid != r_arid);
                    if (rlast) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;

    localparam int OW         = 2;
    localparam int IW         = 4;
    localparam int LINE_BEATS = 1 << OW;
    localparam int LINE_BYTES = 4 * LINE_BEATS;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_uncached, i_ack, i_rready, i_rlast;
    logic [31:0]   i_addr, i_rdata;
    logic          d_req, d_uncached, d_ack, d_rready, d_rlast;
    logic [31:0]   d_addr, d_rdata;
    logic [IW-1:0] arid, rid;
    logic [31:0]   araddr, rdata;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst, rresp;
    logic          arvalid, arready, rlast, rvalid, rready, bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_last_d;   // reference history: dcache won the most recent grant

    always #5 clk = ~clk;

    axi_read_arbiter #(.offset_width(OW), .id_width(IW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_uncached(i_uncached), .i_ack(i_ack),
        .i_rready(i_rready), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_uncached(d_uncached), .d_ack(d_ack),
        .d_rready(d_rready), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .bus_err(bus_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input bit unc);
        if (unc) return a - (a % 4);
        return a - (a % LINE_BYTES);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_uncached = 0;
        d_req = 0; d_addr = 0; d_uncached = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = 0;
        step();
        step();
        check_eq("rst_ctrl", {arvalid, rready, i_ack, d_ack, i_rready, d_rready, i_rlast, d_rlast, bus_err}, 0);
        check_eq("rst_data", {i_rdata, d_rdata}, 0);
        check_eq("rst_ar", {arid, araddr, arlen}, 0);
        check_eq("rst_const", {arsize, arburst}, {3'b010, 2'b01});
        rst = 1'b0;
        m_last_d = 1'b0;
    endtask

    // One complete transaction as the memory slave; expectations from the arbitration rules
    task automatic serve(input int ar_delay, input logic [15:0] pattern, input int nbeats_ovr,
                         input int err_beat, input int bad_rid_beat, input int abort_after, input int mode);
        bit          win_d, unc, lst, exp_err, take;
        logic [31:0] ea, bd;
        logic [7:0]  elen;
        logic [IW-1:0] eid;
        int          nb, k, cyc, seen;
        if (i_req && d_req) win_d = !m_last_d;
        else                win_d = d_req;
        unc  = win_d ? d_uncached : i_uncached;
        ea   = exp_addr(win_d ? d_addr : i_addr, unc);
        elen = unc ? 8'd0 : 8'(LINE_BEATS - 1);
        eid  = win_d ? IW'(1) : IW'(0);
        m_last_d = win_d;

        cyc = 0;
        while (!arvalid && cyc < 8) begin
            step();
            cyc++;
        end
        check_eq("ar_valid", arvalid, 1);
        if (!arvalid) return;
        check_eq("arid", arid, eid);
        check_eq("araddr", araddr, ea);
        check_eq("arlen", arlen, elen);
        check_eq("ar_const", {arsize, arburst}, {3'b010, 2'b01});
        for (int w = 0; w < ar_delay; w++) begin
            check_eq("ack_early", {i_ack, d_ack}, 0);
            step();
            check_eq("ar_hold", {arvalid, arid, araddr, arlen}, {1'b1, eid, ea, elen});
        end
        arready = 1'b1;
        settle();
        check_eq("i_ack", i_ack, !win_d);
        check_eq("d_ack", d_ack, win_d);
        step();
        arready = 1'b0;
        check_eq("ack_pulse", {i_ack, d_ack, arvalid}, 0);

        if (win_d) d_req = 0; else i_req = 0;
        if (mode == 1) begin
            if (win_d) d_req = 1; else i_req = 1;
        end else if (mode == 2) begin
            if ($urandom_range(0, 1) == 1) begin
                if (win_d) begin d_req = 1; d_addr = $urandom; d_uncached = 1'($urandom_range(0, 1)); end
                else       begin i_req = 1; i_addr = $urandom; i_uncached = 1'($urandom_range(0, 1)); end
            end
            if (!i_req && !d_req) begin
                i_req = 1; i_addr = $urandom; i_uncached = 1'($urandom_range(0, 1));
            end
        end

        nb = (nbeats_ovr > 0) ? nbeats_ovr : int'(elen) + 1;
        k = 0; cyc = 0; seen = 0;
        while (k < nb && cyc < 64) begin
            take = (pattern != 0) ? pattern[cyc % 16] : ($urandom_range(0, 3) != 0);
            if (take) begin
                bd = $urandom;
                lst = (k == nb - 1);
                rvalid = 1; rdata = bd; rlast = lst;
                rresp = (k == err_beat) ? 2'b10 : 2'b00;
                rid = (k == bad_rid_beat) ? (eid ^ IW'(1)) : eid;
                exp_err = (k == err_beat) || (k == bad_rid_beat) || (lst && k != int'(elen));
                settle();
                check_eq("rready", rready, 1);
                if (win_d) begin
                    check_eq("d_beat", {d_rready, d_rdata, d_rlast}, {1'b1, bd, lst});
                    check_eq("i_quiet", {i_rready, i_rdata, i_rlast}, 0);
                    if (d_rready) seen++;
                end else begin
                    check_eq("i_beat", {i_rready, i_rdata, i_rlast}, {1'b1, bd, lst});
                    check_eq("d_quiet", {d_rready, d_rdata, d_rlast}, 0);
                    if (i_rready) seen++;
                end
                check_eq("bus_err", bus_err, exp_err);
                k++;
            end else begin
                rvalid = 0; rlast = 0; rresp = 0;
                settle();
                check_eq("gap", {rready, i_rready, d_rready, bus_err}, 4'b1000);
            end
            step();
            cyc++;
            if (abort_after >= 0 && k == abort_after) return;
        end
        rvalid = 0; rlast = 0; rresp = 0;
        check_eq("beats_done", k, nb);
        check_eq("beats_seen", seen, nb);
        settle();
        check_eq("idle_after_last", {rready, arvalid}, 0);
    endtask

    initial begin
        do_reset();

        // Cached icache refill, immediate arready
        i_req = 1; i_addr = 32'h1C00_0014; i_uncached = 0;
        serve(0, 16'hFFFF, 0, -1, -1, -1, 0);

        // Tie after reset: dcache first, then icache wins the re-arbitration tie
        do_reset();
        i_req = 1; i_addr = 32'h0000_1234; i_uncached = 0;
        d_req = 1; d_addr = 32'h8000_00FC; d_uncached = 0;
        serve(0, 16'hFFFF, 0, -1, -1, -1, 1);
        serve(0, 16'hFFFF, 0, -1, -1, -1, 0);
        serve(1, 0, 0, -1, -1, -1, 0);

        // Uncached dcache read with slow arready
        d_req = 1; d_addr = 32'hBFD0_0003; d_uncached = 1;
        serve(5, 16'hFFFF, 0, -1, -1, -1, 0);

        // Gapped R channel 1,0,0,1,1,0,1
        i_req = 1; i_addr = 32'h0000_4008; i_uncached = 0;
        serve(0, 16'h0059, 0, -1, -1, -1, 0);

        // Bad rresp on beat 2, early rlast, rid mismatch
        i_req = 1; i_addr = 32'h0000_5000; i_uncached = 0;
        serve(0, 16'hFFFF, 0, 1, -1, -1, 0);
        d_req = 1; d_addr = 32'h0000_6004; d_uncached = 0;
        serve(0, 16'hFFFF, 3, -1, -1, -1, 0);
        i_req = 1; i_addr = 32'h0000_7000; i_uncached = 1;
        serve(2, 16'hFFFF, 0, -1, 0, -1, 0);

        // Reset during DATA after two beats
        i_req = 1; i_addr = 32'h0000_8000; i_uncached = 0;
        serve(0, 16'hFFFF, 0, -1, -1, 2, 0);
        rst = 1; rvalid = 1; rlast = 0; rid = 0;
        step();
        check_eq("mid_rst", {arvalid, rready, i_rready, d_rready, bus_err}, 0);
        rst = 0; rvalid = 0; m_last_d = 0;
        i_req = 1; i_addr = 32'h0000_9010; i_uncached = 0;
        settle();
        step();
        check_eq("arvalid_1cyc", arvalid, 1);
        serve(0, 16'hFFFF, 0, -1, -1, -1, 2);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            serve($urandom_range(0, 3), 16'h0000,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1,
                  -1, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
